// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the memory stage.
// One bus transaction in flight; data accesses win, redirects squash fetch results.
module mem_port_arbiter #(
    parameter int         DATA_W      = 32,
    parameter logic [1:0] IFETCH_SIZE = 2'b10
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] i_data,
    output logic              i_valid,

    input  logic              d_req,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              keep,

    output logic [DATA_W-1:0] daddr,
    output logic              dreq,
    output logic              dwrite,
    output logic [1:0]        dsize,
    output logic [DATA_W-1:0] input_ddata,
    input  logic [DATA_W-1:0] output_ddata,
    input  logic              dready_n,
    input  logic              dbusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] daddr_q;
    logic              dreq_q;
    logic              dwrite_q;
    logic [1:0]        dsize_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_data_q;
    logic              i_valid_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              d_valid_q;
    logic              drop_q;

    logic              done;
    logic              d_pending;

    assign done      = !dready_n && !dbusy;
    // While d_valid is high, d_req still belongs to the access that just finished.
    assign d_pending = d_req && !d_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            daddr_q   <= '0;
            dreq_q    <= 1'b0;
            dwrite_q  <= 1'b0;
            dsize_q   <= 2'b00;
            wdata_q   <= '0;
            i_data_q  <= '0;
            i_valid_q <= 1'b0;
            d_rdata_q <= '0;
            d_valid_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_pending) begin
                        daddr_q  <= d_addr;
                        dwrite_q <= d_write;
                        dsize_q  <= d_size;
                        wdata_q  <= d_write ? d_wdata : '0;
                        dreq_q   <= 1'b1;
                        state_q  <= D_ACC;
                    end else if (i_req && !flush) begin
                        daddr_q  <= i_addr;
                        dwrite_q <= 1'b0;
                        dsize_q  <= IFETCH_SIZE;
                        wdata_q  <= '0;
                        dreq_q   <= 1'b1;
                        drop_q   <= 1'b0;
                        state_q  <= I_ACC;
                    end else begin
                        dreq_q   <= 1'b0;
                    end
                end

                D_ACC: begin
                    if (done) begin
                        d_rdata_q <= output_ddata;
                        d_valid_q <= 1'b1;
                        dreq_q    <= 1'b0;
                        dwrite_q  <= 1'b0;
                        wdata_q   <= '0;
                        state_q   <= IDLE;
                    end
                end

                I_ACC: begin
                    // The bus cycle always runs to completion; a redirect only squashes the result.
                    if (done) begin
                        dreq_q  <= 1'b0;
                        drop_q  <= 1'b0;
                        state_q <= IDLE;
                        if (!drop_q && !flush) begin
                            i_data_q  <= output_ddata;
                            i_valid_q <= 1'b1;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end

                default: begin
                    dreq_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign keep        = d_pending;
    assign daddr       = daddr_q;
    assign dreq        = dreq_q;
    assign dwrite      = dwrite_q;
    assign dsize       = dsize_q;
    assign input_ddata = wdata_q;
    assign i_data      = i_data_q;
    assign i_valid     = i_valid_q;
    assign d_rdata     = d_rdata_q;
    assign d_valid     = d_valid_q;

endmodule
